inject_queue_ctrl: RTL and testbench
====================================

# inject_queue_ctrl

Local-injection controller between the processing element (PE) and the router's injection arbiter. It buffers PE flits in a small FIFO and presents the head flit to the arbiter with a request. It pops the head on grant and raises a starvation flag when a waiting head flit has been denied a free output slot for too long. A saturating injected-flit counter supports performance monitoring.

## Interface
Parameters:
- DATA_W, 64, flit width in bits
- DEPTH, 4, FIFO entries; power of two, ≥2
- STARVE_TH, 16, denied-request cycles before `starve` asserts; 1..255
- STAT_W, 16, width of the injected-flit counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- pe_valid  in  1  PE offers `pe_flit` this cycle
- pe_flit  in  DATA_W  flit from PE
- pe_ready  out  1  FIFO can accept a flit (= not full)
- inject_req  out  1  head flit waiting; drives arbiter inject request
- inject_flit  out  DATA_W  current head flit; valid while `inject_req`=1
- inject_grant  in  1  arbiter accepted the head flit this cycle
- starve  out  1  head flit denied for STARVE_TH consecutive cycles
- occupancy  out  $clog2(DEPTH)+1  entries held, 0..DEPTH
- inj_count  out  STAT_W  flits injected since reset; saturating

## Operation
- Storage: DEPTH-entry register array with wrapping read and write pointers of $clog2(DEPTH) bits each. `occupancy` is an explicit counter.
- Push = pe_valid & pe_ready. Pop = inject_req & inject_grant.
- `pe_ready` = (occupancy != DEPTH). It never depends on `inject_grant`, so a full FIFO refuses a push even when a pop happens in the same cycle.
- Push and pop in the same cycle (not full, not empty): both pointers advance and occupancy is unchanged.
- `inject_req` = (occupancy != 0). `inject_flit` = array[rd_ptr], from registers with no combinational path from `pe_flit`.
- `inject_grant` while `inject_req`=0 is ignored: no pointer, counter or state change.
- State machine, registered:
  - IDLE: FIFO empty. Moves to REQ when occupancy becomes non-zero.
  - REQ: requesting, wait count below STARVE_TH.
    - Grant with FIFO left empty → IDLE.
    - Grant with entries left → REQ, wait count cleared.
    - Denied cycle → wait count +1. Moves to STARVE when the count reaches STARVE_TH.
  - STARVE: `starve`=1.
    - Grant with FIFO left empty → IDLE.
    - Grant with entries left → REQ, wait count cleared.
    - Otherwise stays in STARVE.
- Wait count: 8-bit, saturates at STARVE_TH, cleared on every pop and in IDLE.
- `starve` = (state == STARVE), registered.
- `inj_count` increments by 1 on each pop and holds at 2^STAT_W−1.

## Timing
- Reset, rst_n=0 at a clock edge: pointers, occupancy, wait count and inj_count go to 0, and state goes to IDLE.
  - Outputs after that edge: pe_ready=1, inject_req=0, starve=0, occupancy=0, inj_count=0.
  - Array contents are not reset, so `inject_flit` is don't-care while `inject_req`=0.
- Reset mid-operation discards all queued flits. A grant sampled in the same cycle as reset has no effect.
- Fill latency: a flit pushed at edge N gives inject_req=1 and that flit on `inject_flit` after edge N, i.e. in cycle N+1. There is no bypass from PE to arbiter.
- Grant handshake: the arbiter samples `inject_req`/`inject_flit` and returns `inject_grant` in the same cycle. The pop happens at that cycle's edge, and the next head or `inject_req`=0 appears the following cycle.
- Back-to-back grants pop one flit per cycle.
- Starvation timing: with the head waiting and grant held at 0 from cycle 1 (the first `inject_req` cycle), `starve` rises in cycle STARVE_TH+1. It falls in the cycle after the granting cycle.

## Test plan
- Reset, then 3 PE pushes 0xA1, 0xA2, 0xA3 with grant held high → inject_flit shows A1, A2, A3 in consecutive cycles starting 1 cycle after the first push; occupancy returns to 0; inj_count=3; starve never asserts.
- Fill with grant=0: push 5 flits into DEPTH=4 → pe_ready=0 after the 4th push and the 5th is refused. Then grant 1 cycle while pe_valid=1 → head popped, 5th flit still refused that cycle, accepted the next cycle, occupancy=4.
- Starvation, STARVE_TH=16: push 1 flit, hold grant=0 → starve=1 in the 17th request cycle. Grant in cycle 20 → starve=0 and inject_req=0 in cycle 21; state IDLE.
- Spurious grant: FIFO empty, inject_grant=1 for 3 cycles → occupancy, inj_count and pointers unchanged.
- Wrap-around: 10 pushes with 10 grants interleaved, each grant issued 2 cycles after its push → pointers wrap twice, flits emerge in order, inj_count=10.
- Mid-operation reset: occupancy=3 and starve=1, then assert rst_n=0 for 1 cycle with grant=1 → every output at its reset value after the edge; the grant is not counted.

Source files
------------

// File: rtl/inject_queue_ctrl.sv
// Local-injection controller: buffers PE flits in a small FIFO, requests the
// router injection arbiter with the head flit and flags prolonged starvation.
module inject_queue_ctrl #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned STARVE_TH = 16,
    parameter int unsigned STAT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pe_valid,
    input  logic [DATA_W-1:0]        pe_flit,
    output logic                     pe_ready,
    output logic                     inject_req,
    output logic [DATA_W-1:0]        inject_flit,
    input  logic                     inject_grant,
    output logic                     starve,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [STAT_W-1:0]        inj_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] OCC_FULL = (AW + 1)'(DEPTH);
    localparam logic [7:0] WAIT_TH = 8'(STARVE_TH);
    localparam logic [STAT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_STARVE
    } state_t;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       occ_q, occ_d;
    logic [7:0]        wait_q, wait_d;
    logic [STAT_W-1:0] cnt_q, cnt_d;
    state_t            state_q, state_d;
    logic              push;
    logic              pop;

    // Ready looks only at occupancy, so a full FIFO refuses a push even while popping.
    assign pe_ready    = (occ_q != OCC_FULL);
    assign inject_req  = (occ_q != '0);
    assign push        = pe_valid & pe_ready;
    assign pop         = inject_req & inject_grant;
    assign inject_flit = mem_q[rd_ptr_q];
    assign starve      = (state_q == ST_STARVE);
    assign occupancy   = occ_q;
    assign inj_count   = cnt_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + STAT_W'(1);
            end
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + (AW + 1)'(1);
            2'b01:   occ_d = occ_q - (AW + 1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_IDLE: begin
                wait_d = '0;
                if (occ_d != '0) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (pop) begin
                    wait_d  = '0;
                    state_d = (occ_d == '0) ? ST_IDLE : ST_REQ;
                end else begin
                    wait_d = (wait_q < WAIT_TH) ? wait_q + 8'd1 : wait_q;
                    if (wait_d >= WAIT_TH) begin
                        state_d = ST_STARVE;
                    end
                end
            end
            ST_STARVE: begin
                if (pop) begin
                    wait_d  = '0;
                    state_d = (occ_d == '0) ? ST_IDLE : ST_REQ;
                end
            end
            default: begin
                wait_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            wait_q   <= '0;
            cnt_q    <= '0;
            state_q  <= ST_IDLE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            wait_q   <= wait_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
        end
    end

    // Storage is not reset; its contents are only observed while inject_req is high.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pe_flit;
        end
    end

endmodule

// File: tb/tb_inject_queue_ctrl.sv
// Scoreboard bench for inject_queue_ctrl: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_inject_queue_ctrl;

    localparam int unsigned DATA_W    = 64;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned STARVE_TH = 16;
    localparam int unsigned STAT_W    = 5;
    localparam int unsigned CNT_MAX   = (1 << STAT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   pe_valid;
    logic [DATA_W-1:0]      pe_flit;
    logic                   pe_ready;
    logic                   inject_req;
    logic [DATA_W-1:0]      inject_flit;
    logic                   inject_grant;
    logic                   starve;
    logic [$clog2(DEPTH):0] occupancy;
    logic [STAT_W-1:0]      inj_count;

    int unsigned tests  = 0;
    int unsigned failed = 0;

    inject_queue_ctrl #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .STARVE_TH(STARVE_TH),
        .STAT_W   (STAT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pe_valid    (pe_valid),
        .pe_flit     (pe_flit),
        .pe_ready    (pe_ready),
        .inject_req  (inject_req),
        .inject_flit (inject_flit),
        .inject_grant(inject_grant),
        .starve      (starve),
        .occupancy   (occupancy),
        .inj_count   (inj_count)
    );

    always #5 clk = ~clk;

    // Reference model: queued flits in order, denied-cycle count of the current head,
    // and number of flits injected since reset.
    logic [DATA_W-1:0] sb_q[$];
    int unsigned       m_wait;
    int unsigned       m_cnt;
    bit                checking = 1'b0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin
        bit req, pop, push;
        forever begin
            @(negedge clk);
            if (checking) begin
                chk("pe_ready",   DATA_W'(pe_ready),   DATA_W'(sb_q.size() != DEPTH));
                chk("inject_req", DATA_W'(inject_req), DATA_W'(sb_q.size() != 0));
                chk("occupancy",  DATA_W'(occupancy),  DATA_W'(sb_q.size()));
                chk("starve",     DATA_W'(starve),     DATA_W'(m_wait >= STARVE_TH));
                chk("inj_count",  DATA_W'(inj_count),  DATA_W'(m_cnt));
                if (sb_q.size() != 0) begin
                    chk("inject_flit", inject_flit, sb_q[0]);
                end
            end
            if (rst_n !== 1'b1) begin
                sb_q.delete();
                m_wait   = 0;
                m_cnt    = 0;
                checking = 1'b1;
            end else begin
                req  = (sb_q.size() != 0);
                pop  = req && (inject_grant === 1'b1);
                push = (pe_valid === 1'b1) && (sb_q.size() != DEPTH);
                if (pop) begin
                    void'(sb_q.pop_front());
                    if (m_cnt < CNT_MAX) m_cnt++;
                end
                if (push) sb_q.push_back(pe_flit);
                if (!req || pop) m_wait = 0;
                else if (m_wait < STARVE_TH) m_wait++;
            end
        end
    end

    task automatic cyc(input logic v, input logic [DATA_W-1:0] f, input logic g, input logic r);
        pe_valid     = v;
        pe_flit      = f;
        inject_grant = g;
        rst_n        = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n, input logic g);
        for (int unsigned i = 0; i < n; i++) cyc(1'b0, '0, g, 1'b1);
    endtask

    task automatic do_reset();
        cyc(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        int unsigned gp;
        logic [DATA_W-1:0] rf;
        pe_valid     = 1'b0;
        pe_flit      = '0;
        inject_grant = 1'b0;
        rst_n        = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        idle(2, 1'b0);

        // Streaming with grant held high
        cyc(1'b1, 64'hA1, 1'b1, 1'b1);
        cyc(1'b1, 64'hA2, 1'b1, 1'b1);
        cyc(1'b1, 64'hA3, 1'b1, 1'b1);
        idle(4, 1'b1);
        do_reset();

        // Fill past capacity, then pop while a push is refused
        for (int unsigned i = 1; i <= 5; i++) cyc(1'b1, DATA_W'(64'hB0 + i), 1'b0, 1'b1);
        cyc(1'b1, 64'hB5, 1'b1, 1'b1);
        cyc(1'b1, 64'hB5, 1'b0, 1'b1);
        idle(2, 1'b0);
        idle(6, 1'b1);
        do_reset();

        // Starvation: one flit, denied 19 cycles, granted in cycle 20
        cyc(1'b1, 64'hC1, 1'b0, 1'b1);
        idle(19, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);

        // Spurious grants on an empty FIFO
        idle(3, 1'b1);
        idle(1, 1'b0);
        do_reset();

        // Wrap-around: each grant two cycles after its push
        for (int unsigned i = 0; i < 10; i++) begin
            cyc(1'b1, DATA_W'(64'hD0 + i), 1'b0, 1'b1);
            idle(1, 1'b0);
            idle(1, 1'b1);
        end
        idle(2, 1'b0);

        // Mid-operation reset with grant asserted
        for (int unsigned i = 0; i < 3; i++) cyc(1'b1, DATA_W'(64'hE0 + i), 1'b0, 1'b1);
        idle(18, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        idle(3, 1'b0);

        // Random traffic in blocks of low, medium and high grant probability
        for (int unsigned blk = 0; blk < 15; blk++) begin
            gp = (blk % 3 == 0) ? 4 : ((blk % 3 == 1) ? 50 : 95);
            for (int unsigned i = 0; i < 200; i++) begin
                rf = {$urandom, $urandom};
                cyc($urandom_range(0, 99) < 60, rf, $urandom_range(0, 99) < gp,
                    $urandom_range(0, 999) != 0);
            end
        end
        idle(8, 1'b1);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
